// File: rtl/psum_seq_ctrl.sv
// Partial-sum bank sequencer: accepts one tile per input channel, sweeps the bank
// column by column (overwrite on channel 0, accumulate after), then hands the map off.
module psum_seq_ctrl #(
    parameter int W        = 11,
    parameter int NUM_CHAN = 10,
    parameter int COL_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             tile_valid,
    output logic             tile_ready,
    output logic             col_we,
    output logic [COL_W-1:0] col_idx,
    output logic             acc_mode,
    output logic [3:0]       cal_chan,
    output logic             ps_valid,
    input  logic             ps_ready,
    output logic             busy,
    output logic             done,
    output logic             err_start
);

    generate
        if (NUM_CHAN < 2 || NUM_CHAN > 16 || W < 1 || (64'd1 << COL_W) < 64'(W)) begin : g_bad_params
            $error("psum_seq_ctrl: unsupported W/NUM_CHAN/COL_W combination");
        end
    endgenerate

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(W - 1);
    localparam logic [3:0]       LAST_CHAN = 4'(NUM_CHAN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TILE,
        S_SWEEP,
        S_STEP,
        S_OUTPUT
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [3:0]       chan_q, chan_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            chan_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            chan_q  <= chan_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // abort overrides everything, including a coincident start or handshake
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        chan_d  = chan_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            col_d   = '0;
        end else begin
            if (start && (state_q != S_IDLE)) begin
                err_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        chan_d  = '0;
                        col_d   = '0;
                        state_d = S_WAIT_TILE;
                    end
                end
                S_WAIT_TILE: begin
                    if (tile_valid) begin
                        col_d   = '0;
                        state_d = S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = S_STEP;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                S_STEP: begin
                    if (chan_q == LAST_CHAN) begin
                        state_d = S_OUTPUT;
                    end else begin
                        chan_d  = chan_q + 4'd1;
                        state_d = S_WAIT_TILE;
                    end
                end
                S_OUTPUT: begin
                    if (ps_ready) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    col_d   = '0;
                end
            endcase
        end
    end

    assign tile_ready = (state_q == S_WAIT_TILE);
    assign col_we     = (state_q == S_SWEEP);
    assign col_idx    = col_q;
    assign acc_mode   = (state_q == S_SWEEP) && (chan_q != 4'd0);
    assign cal_chan   = chan_q;
    assign ps_valid   = (state_q == S_OUTPUT);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err_start  = err_q;

endmodule

// File: tb/tb_psum_seq_ctrl.sv
// Scoreboard bench for psum_seq_ctrl: every expected bank write is queued when a
// map is started and checked against each col_we cycle.
module tb_psum_seq_ctrl;

    localparam int W        = 11;
    localparam int NUM_CHAN = 10;
    localparam int COL_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             tile_valid;
    logic             tile_ready;
    logic             col_we;
    logic [COL_W-1:0] col_idx;
    logic             acc_mode;
    logic [3:0]       cal_chan;
    logic             ps_valid;
    logic             ps_ready;
    logic             busy;
    logic             done;
    logic             err_start;

    psum_seq_ctrl #(.W(W), .NUM_CHAN(NUM_CHAN), .COL_W(COL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .tile_valid(tile_valid),
        .tile_ready(tile_ready),
        .col_we    (col_we),
        .col_idx   (col_idx),
        .acc_mode  (acc_mode),
        .cal_chan  (cal_chan),
        .ps_valid  (ps_valid),
        .ps_ready  (ps_ready),
        .busy      (busy),
        .done      (done),
        .err_start (err_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       chan;
        logic [COL_W-1:0] col;
        logic             acc;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  we_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_map();
        wr_t e;
        for (int c = 0; c < NUM_CHAN; c++) begin
            for (int k = 0; k < W; k++) begin
                e.chan = 4'(c);
                e.col  = COL_W'(k);
                e.acc  = (c != 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 300) begin
            step();
            k++;
        end
        check(tag, 32'(done), 32'd1);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard monitor and invariants, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (col_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check("we_unexpected", 32'(col_we), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("we_data", 32'({cal_chan, col_idx, acc_mode}), 32'(e));
                end
            end
            if (done && busy) check("done_and_busy", 32'd1, 32'd0);
            if (col_idx > COL_W'(W - 1)) check("col_range", 32'(col_idx), 32'(W - 1));
            if (cal_chan > 4'(NUM_CHAN - 1)) check("chan_range", 32'(cal_chan), 32'(NUM_CHAN - 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int glitch;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        tile_valid = 1'b0;
        ps_ready   = 1'b0;
        #1;
        check("reset_outs", 32'({tile_ready, col_we, col_idx, acc_mode, cal_chan,
                                 ps_valid, busy, done, err_start}), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1: reset mid-sweep at column 5
        tile_valid = 1'b1;
        push_map();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(col_we && col_idx == COL_W'(5)) && k < 50) begin
            step();
            k++;
        end
        check("reach_col5", 32'(col_we), 32'd1);
        rst = 1'b1;
        #1;
        check("midsweep_reset_outs", 32'({tile_ready, col_we, col_idx, acc_mode, cal_chan,
                                          ps_valid, busy, done, err_start}), 32'd0);
        exp_q.delete();
        step();
        rst = 1'b0;
        glitch = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (col_we || busy) glitch++;
        end
        check("post_reset_idle", 32'(glitch), 32'd0);

        // 2: nominal run, tile_valid and ps_ready tied high
        ps_ready = 1'b1;
        we_cnt   = 0;
        push_map();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!ps_valid && n < 400) begin
            step();
            n++;
        end
        check("nominal_ps_valid_lat", 32'(n), 32'd131);
        step();
        check("nominal_done_lat", 32'(done), 32'd1);
        check("nominal_done_busy", 32'(busy), 32'd0);
        step();
        check("nominal_done_pulse", 32'(done), 32'd0);
        check("nominal_we_total", 32'(we_cnt), 32'd110);
        check("nominal_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: 5-cycle tile stall before each channel
        tile_valid = 1'b0;
        push_map();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            k = 0;
            while (!tile_ready && k < 50) begin
                step();
                k++;
            end
            check("stall_chan_order", 32'(cal_chan), 32'(c));
            glitch = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (!tile_ready || col_we) glitch++;
            end
            check("stall_hold", 32'(glitch), 32'd0);
            tile_valid = 1'b1;
            step();
            tile_valid = 1'b0;
            check("stall_accept", 32'(col_we), 32'd1);
        end
        wait_done("stall_done");
        step();

        // 4: downstream backpressure for 20 cycles
        tile_valid = 1'b1;
        ps_ready   = 1'b0;
        push_map();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!ps_valid && k < 400) begin
            step();
            k++;
        end
        check("bp_ps_valid", 32'(ps_valid), 32'd1);
        glitch = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!ps_valid || done) glitch++;
        end
        check("bp_valid_stable", 32'(glitch), 32'd0);
        ps_ready = 1'b1;
        step();
        check("bp_done", 32'(done), 32'd1);
        check("bp_valid_drop", 32'(ps_valid), 32'd0);
        check("bp_cal_hold", 32'(cal_chan), 32'(NUM_CHAN - 1));
        step();
        check("bp_done_pulse", 32'(done), 32'd0);

        // 5: abort at channel 4, column 3, then restart
        push_map();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(col_we && cal_chan == 4'd4 && col_idx == COL_W'(3)) && k < 200) begin
            step();
            k++;
        end
        check("reach_ch4_col3", 32'(col_we), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        check("abort_state", 32'({busy, col_we, ps_valid, done}), 32'd0);
        glitch = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done || busy) glitch++;
        end
        check("abort_no_done", 32'(glitch), 32'd0);
        push_map();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_chan0", 32'(cal_chan), 32'd0);
        wait_done("restart_done");
        step();

        // 6: start pulsed mid-sweep must not disturb timing
        push_map();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!ps_valid && n < 400) begin
            if (n == 30) start = 1'b1;
            step();
            n++;
            if (n == 31) begin
                start = 1'b0;
                check("err_start_pulse", 32'(err_start), 32'd1);
            end
            if (n == 32) check("err_start_clear", 32'(err_start), 32'd0);
        end
        check("err_run_lat", 32'(n), 32'd131);
        wait_done("err_run_done");
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'({busy, tile_ready, err_start}), 32'd0);
        step();
        check("start_abort_stay", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
